neur_requant_unit: RTL and testbench



---
 rtl/neur_requant_pkg.sv | 62 ++++++
 rtl/neur_requant_if.sv | 28 ++
 rtl/neur_requant_lane.sv | 29 ++
 rtl/neur_requant_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_neur_requant_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/neur_requant_pkg.sv
// Shared types, widths and clamp helpers for the requantisation unit.
// Optional saturation counter is enabled by NEUR_REQUANT_SAT_CNT_EN.
package neur_requant_pkg;

    typedef enum logic [1:0] {
        PREC8 = 2'b00,
        PREC4 = 2'b01,
        PREC2 = 2'b10
    } prec_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MUL   = 2'b01,
        ROUND = 2'b10,
        OUT   = 2'b11
    } state_e;

    localparam int SAT_CNT_W = 16;
    localparam int SLOT_W    = 8;
    // Working width for clamping; callers sign-extend their rounded value into it.
    localparam int CLAMP_W   = 64;

    function automatic logic signed [CLAMP_W-1:0] clamp_full(
        input logic signed [CLAMP_W-1:0] r,
        input prec_e                     prec,
        input logic                      relu
    );
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        int unsigned               p;
        case (prec)
            PREC4:   p = 32'd4;
            PREC2:   p = 32'd2;
            default: p = 32'd8;
        endcase
        if (relu) begin
            hi = (64'sd1 <<< p) - 64'sd1;
            lo = 64'sd0;
        end else begin
            hi = (64'sd1 <<< (p - 32'd1)) - 64'sd1;
            lo = -(64'sd1 <<< (p - 32'd1));
        end
        if (r > hi) begin
            clamp_full = hi;
        end else if (r < lo) begin
            clamp_full = lo;
        end else begin
            clamp_full = r;
        end
    endfunction

    function automatic logic [SLOT_W-1:0] clamp_val(
        input logic signed [CLAMP_W-1:0] r,
        input prec_e                     prec,
        input logic                      relu
    );
        logic signed [CLAMP_W-1:0] full;
        full      = clamp_full(r, prec, relu);
        clamp_val = full[SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/neur_requant_if.sv
// Accumulator-in / packed-result-out handshake bundle of the requantisation unit.
interface neur_requant_if #(
    parameter int NUM_CH  = 4,
    parameter int ACC_W   = 32,
    parameter int MUL_W   = 8,
    parameter int SHIFT_W = 5
) ();
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [NUM_CH*ACC_W-1:0]   acc_i;
    logic [NUM_CH*MUL_W-1:0]   mul_i;
    logic [NUM_CH*SHIFT_W-1:0] shift_i;
    logic                      relu_i;
    logic [1:0]                prec_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [NUM_CH*8-1:0]       out_data_o;

    modport slave (
        input  in_valid_i, acc_i, mul_i, shift_i, relu_i, prec_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, acc_i, mul_i, shift_i, relu_i, prec_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/neur_requant_lane.sv
// One multiplier lane: exact signed product acc * mul via an ACC_W+1 bit magnitude.
module neur_requant_lane #(
    parameter int ACC_W = 32,
    parameter int MUL_W = 8
) (
    input  logic signed [ACC_W-1:0]       acc_i,
    input  logic        [MUL_W-1:0]       mul_i,
    output logic signed [ACC_W+MUL_W+1:0] y_o
);
    logic signed [ACC_W:0]       acc_ext_s;
    logic        [ACC_W:0]       mag_s;
    logic        [ACC_W+MUL_W:0] prod_s;

    // Magnitude, unsigned multiply, then restore the sign.
    always_comb begin
        acc_ext_s = {acc_i[ACC_W-1], acc_i};
        if (acc_i[ACC_W-1]) begin
            mag_s = -acc_ext_s;
        end else begin
            mag_s = acc_ext_s;
        end
        prod_s = {{MUL_W{1'b0}}, mag_s} * {{(ACC_W+1){1'b0}}, mul_i};
        if (acc_i[ACC_W-1]) begin
            y_o = -signed'({1'b0, prod_s});
        end else begin
            y_o = signed'({1'b0, prod_s});
        end
    end
endmodule

// File: rtl/neur_requant_unit.sv
// Requantisation stage: time-multiplexed scale, rounding shift, clamp and pack.
// Define NEUR_REQUANT_SAT_CNT_EN to add the saturation counter (sat_clr_i, sat_cnt_o).
module neur_requant_unit
    import neur_requant_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MUL_LANES = 2,
    parameter int ACC_W     = 32,
    parameter int MUL_W     = 8,
    parameter int SHIFT_W   = 5
) (
    input  logic                 clk_i_fast,
    input  logic                 rst_ni,
`ifdef NEUR_REQUANT_SAT_CNT_EN
    input  logic                 sat_clr_i,
    output logic [SAT_CNT_W-1:0] sat_cnt_o,
`endif
    neur_requant_if.slave        bus
);
    localparam int NUM_GRP = NUM_CH / MUL_LANES;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int Y_W     = ACC_W + MUL_W + 2;
    localparam int R_W     = Y_W + 1;
    localparam int OUT_W   = NUM_CH * SLOT_W;
    localparam int HIT_W   = $clog2(NUM_CH + 1);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRP - 1);

    state_e                    state_q, state_d;
    logic [GRP_W-1:0]          grp_q, grp_d;
    logic signed [ACC_W-1:0]   acc_q   [NUM_CH];
    logic signed [ACC_W-1:0]   acc_d   [NUM_CH];
    logic [MUL_W-1:0]          mul_q   [NUM_CH];
    logic [MUL_W-1:0]          mul_d   [NUM_CH];
    logic [SHIFT_W-1:0]        shift_q [NUM_CH];
    logic [SHIFT_W-1:0]        shift_d [NUM_CH];
    logic signed [Y_W-1:0]     y_q     [NUM_CH];
    logic signed [Y_W-1:0]     y_d     [NUM_CH];
    logic                      relu_q, relu_d;
    logic [1:0]                prec_q, prec_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;

    logic signed [ACC_W-1:0]   lane_acc_s [MUL_LANES];
    logic [MUL_W-1:0]          lane_mul_s [MUL_LANES];
    logic signed [Y_W-1:0]     lane_y_s   [MUL_LANES];
    logic [HIT_W-1:0]          hit_cnt_s;

    for (genvar l = 0; l < MUL_LANES; l++) begin : g_lane
        neur_requant_lane #(.ACC_W(ACC_W), .MUL_W(MUL_W)) u_lane (
            .acc_i (lane_acc_s[l]),
            .mul_i (lane_mul_s[l]),
            .y_o   (lane_y_s[l])
        );
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;

    // FSM next state, group counter and output-valid flag.
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    state_d = MUL;
                    grp_d   = {GRP_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (grp_q == LAST_GRP) begin
                    state_d = ROUND;
                    grp_d   = {GRP_W{1'b0}};
                end else begin
                    grp_d = grp_q + {{(GRP_W-1){1'b0}}, 1'b1};
                end
            end
            ROUND: begin
                state_d     = OUT;
                out_valid_d = 1'b1;
            end
            OUT: begin
                if (bus.out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Input capture and lane operand selection / product write-back.
    always_comb begin
        acc_d   = acc_q;
        mul_d   = mul_q;
        shift_d = shift_q;
        y_d     = y_q;
        relu_d  = relu_q;
        prec_d  = prec_q;
        for (int l = 0; l < MUL_LANES; l++) begin
            lane_acc_s[l] = '0;
            lane_mul_s[l] = '0;
        end
        if ((state_q == IDLE) && bus.in_valid_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_d[c]   = bus.acc_i[(NUM_CH-1-c)*ACC_W +: ACC_W];
                mul_d[c]   = bus.mul_i[(NUM_CH-1-c)*MUL_W +: MUL_W];
                shift_d[c] = bus.shift_i[(NUM_CH-1-c)*SHIFT_W +: SHIFT_W];
            end
            relu_d = bus.relu_i;
            prec_d = bus.prec_i;
        end else begin
            relu_d = relu_q;
        end
        for (int g = 0; g < NUM_GRP; g++) begin
            if (GRP_W'(g) == grp_q) begin
                for (int l = 0; l < MUL_LANES; l++) begin
                    lane_acc_s[l] = acc_q[g*MUL_LANES+l];
                    lane_mul_s[l] = mul_q[g*MUL_LANES+l];
                end
            end else begin
                lane_acc_s = lane_acc_s;
            end
        end
        if (state_q == MUL) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                if (GRP_W'(g) == grp_q) begin
                    for (int l = 0; l < MUL_LANES; l++) begin
                        y_d[g*MUL_LANES+l] = lane_y_s[l];
                    end
                end else begin
                    y_d = y_d;
                end
            end
        end else begin
            y_d = y_d;
        end
    end

    // Rounding shift, clamp and pack of all channels in ROUND.
    always_comb begin
        logic [R_W-1:0]            rnd;
        logic signed [R_W-1:0]     sum;
        logic signed [R_W-1:0]     r;
        logic signed [CLAMP_W-1:0] r_wide;
        logic signed [CLAMP_W-1:0] r_clamp;
        logic [SLOT_W-1:0]         v;
        logic [NUM_CH*8-1:0]       pack8;
        logic [NUM_CH*4-1:0]       pack4;
        logic [NUM_CH*2-1:0]       pack2;
        pack8      = '0;
        pack4      = '0;
        pack2      = '0;
        hit_cnt_s  = '0;
        out_data_d = out_data_q;
        for (int c = 0; c < NUM_CH; c++) begin
            rnd = '0;
            if (shift_q[c] != {SHIFT_W{1'b0}}) begin
                rnd = {{(R_W-1){1'b0}}, 1'b1} << (shift_q[c] - {{(SHIFT_W-1){1'b0}}, 1'b1});
            end else begin
                rnd = '0;
            end
            sum     = {y_q[c][Y_W-1], y_q[c]} + signed'(rnd);
            r       = sum >>> shift_q[c];
            r_wide  = {{(CLAMP_W-R_W){r[R_W-1]}}, r};
            r_clamp = clamp_full(r_wide, prec_e'(prec_q), relu_q);
            v       = clamp_val(r_wide, prec_e'(prec_q), relu_q);
            if (r_clamp != r_wide) begin
                hit_cnt_s = hit_cnt_s + {{(HIT_W-1){1'b0}}, 1'b1};
            end else begin
                hit_cnt_s = hit_cnt_s;
            end
            pack8[(NUM_CH-1-c)*8 +: 8] = v;
            pack4[(NUM_CH-1-c)*4 +: 4] = v[3:0];
            pack2[(NUM_CH-1-c)*2 +: 2] = v[1:0];
        end
        if (state_q == ROUND) begin
            case (prec_q)
                2'b01:   out_data_d = {{(OUT_W-NUM_CH*4){1'b0}}, pack4};
                2'b10:   out_data_d = {{(OUT_W-NUM_CH*2){1'b0}}, pack2};
                default: out_data_d = pack8;
            endcase
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk_i_fast or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grp_q       <= '0;
            relu_q      <= 1'b0;
            prec_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]   <= '0;
                mul_q[c]   <= '0;
                shift_q[c] <= '0;
                y_q[c]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            relu_q      <= relu_d;
            prec_q      <= prec_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            mul_q       <= mul_d;
            shift_q     <= shift_d;
            y_q         <= y_d;
        end
    end

`ifdef NEUR_REQUANT_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic [SAT_CNT_W:0]   sat_sum_s;

    // Saturating count of clamped channels; clear wins over increment.
    always_comb begin
        sat_sum_s = {1'b0, sat_cnt_q} + {{(SAT_CNT_W+1-HIT_W){1'b0}}, hit_cnt_s};
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (state_q == ROUND) begin
            if (sat_sum_s[SAT_CNT_W]) begin
                sat_cnt_d = {SAT_CNT_W{1'b1}};
            end else begin
                sat_cnt_d = sat_sum_s[SAT_CNT_W-1:0];
            end
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk_i_fast or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_neur_requant_unit.sv
// Directed self-checking bench for neur_requant_unit (default parameters).
module tb_neur_requant_unit;
    logic clk_i_fast;
    logic rst_ni;
    int   n_checks;
    int   n_fail;

    neur_requant_if #(.NUM_CH(4), .ACC_W(32), .MUL_W(8), .SHIFT_W(5)) bus_if ();

`ifdef NEUR_REQUANT_SAT_CNT_EN
    logic        sat_clr_i;
    logic [15:0] sat_cnt_o;
`endif

    neur_requant_unit #(
        .NUM_CH(4), .MUL_LANES(2), .ACC_W(32), .MUL_W(8), .SHIFT_W(5)
    ) dut (
        .clk_i_fast (clk_i_fast),
        .rst_ni     (rst_ni),
`ifdef NEUR_REQUANT_SAT_CNT_EN
        .sat_clr_i  (sat_clr_i),
        .sat_cnt_o  (sat_cnt_o),
`endif
        .bus        (bus_if)
    );

    initial clk_i_fast = 1'b0;
    always #5 clk_i_fast = ~clk_i_fast;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a set, wait for out_valid, check latency and data (out_ready_i stays high).
    task automatic run_set(input string tag, input logic [127:0] acc, input logic [31:0] mul,
                           input logic [19:0] shf, input logic relu, input logic [1:0] prec,
                           input logic [31:0] exp_data);
        int lat;
        @(negedge clk_i_fast);
        check({tag, "_in_ready"}, {63'd0, bus_if.in_ready_o}, 64'd1);
        bus_if.in_valid_i = 1'b1;
        bus_if.acc_i      = acc;
        bus_if.mul_i      = mul;
        bus_if.shift_i    = shf;
        bus_if.relu_i     = relu;
        bus_if.prec_i     = prec;
        @(posedge clk_i_fast);
        #1;
        bus_if.in_valid_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_i_fast);
            #1;
            if (bus_if.out_valid_o && lat == 0) lat = i;
        end
        check({tag, "_latency"}, 64'(lat), 64'd0 + 64'd3 * 64'(lat != 0 && lat == 3) + 64'(lat != 3) * 64'd3);
        check({tag, "_data"}, {32'd0, bus_if.out_data_o}, {32'd0, exp_data});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_ni   = 1'b0;
        bus_if.in_valid_i  = 1'b0;
        bus_if.acc_i       = '0;
        bus_if.mul_i       = '0;
        bus_if.shift_i     = '0;
        bus_if.relu_i      = 1'b0;
        bus_if.prec_i      = 2'b00;
        bus_if.out_ready_i = 1'b1;
`ifdef NEUR_REQUANT_SAT_CNT_EN
        sat_clr_i = 1'b0;
`endif
        repeat (3) @(negedge clk_i_fast);
        check("rst_in_ready", {63'd0, bus_if.in_ready_o}, 64'd1);
        check("rst_out_valid", {63'd0, bus_if.out_valid_o}, 64'd0);
        check("rst_out_data", {32'd0, bus_if.out_data_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i_fast);
        check("post_rst_in_ready", {63'd0, bus_if.in_ready_o}, 64'd1);
`ifdef NEUR_REQUANT_SAT_CNT_EN
        check("rst_sat_cnt", {48'd0, sat_cnt_o}, 64'd0);
`endif

        // 1000*3 = 3000, +8 >>> 4 = 188 -> 127 in every channel.
        run_set("s8_pos", {4{32'd1000}}, 32'h03030303, {4{5'd4}}, 1'b0, 2'b00, 32'h7F7F7F7F);
`ifdef NEUR_REQUANT_SAT_CNT_EN
        check("sat_cnt_4", {48'd0, sat_cnt_o}, 64'd4);
`endif
        @(negedge clk_i_fast);
        check("s8_pos_done", {63'd0, bus_if.out_valid_o}, 64'd0);

        // -3000 + 8 >>> 4 = -187 -> -128 signed, 0 with ReLU.
        run_set("s8_neg", {4{-32'sd1000}}, 32'h03030303, {4{5'd4}}, 1'b0, 2'b00, 32'h80808080);
        run_set("relu_neg", {4{-32'sd1000}}, 32'h03030303, {4{5'd4}}, 1'b1, 2'b00, 32'h00000000);

        // 4-bit ReLU: 13, 2, 25->15, -1->0.
        run_set("p4_relu", {32'd100, 32'd16, 32'd200, -32'sd5}, 32'h01010101, {4{5'd3}},
                1'b1, 2'b01, 32'h0000D2F0);

        // shift 0: 10 -> 1 in each signed 2-bit slot.
        run_set("p2_shift0", {4{32'd5}}, 32'h02020202, {4{5'd0}}, 1'b0, 2'b10, 32'h00000055);

        // Most-negative accumulator, mul 1, shift 31: (-2^31 + 2^30) >>> 31 = -1.
        run_set("min_acc", {4{32'h80000000}}, 32'h01010101, {4{5'd31}}, 1'b0, 2'b11, 32'hFFFFFFFF);

        // Backpressure: result must be held while out_ready_i is low.
        @(negedge clk_i_fast);
        bus_if.out_ready_i = 1'b0;
        run_set("bp", {32'd7, 32'd1, 32'd2, 32'd3}, 32'h01010101, {4{5'd0}}, 1'b0, 2'b00, 32'h07010203);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i_fast);
            check("bp_valid_hold", {63'd0, bus_if.out_valid_o}, 64'd1);
            check("bp_data_hold", {32'd0, bus_if.out_data_o}, 64'h07010203);
            check("bp_in_ready_low", {63'd0, bus_if.in_ready_o}, 64'd0);
        end
        bus_if.out_ready_i = 1'b1;
        @(posedge clk_i_fast);
        #1;
        check("bp_released_valid", {63'd0, bus_if.out_valid_o}, 64'd0);
        check("bp_released_ready", {63'd0, bus_if.in_ready_o}, 64'd1);

        // Reset during MUL aborts the set.
        @(negedge clk_i_fast);
        bus_if.in_valid_i = 1'b1;
        bus_if.acc_i      = {4{32'd1000}};
        bus_if.mul_i      = 32'h03030303;
        bus_if.shift_i    = {4{5'd4}};
        bus_if.relu_i     = 1'b0;
        bus_if.prec_i     = 2'b00;
        @(posedge clk_i_fast);
        #1;
        bus_if.in_valid_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i_fast);
        rst_ni = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_i_fast);
                if (bus_if.out_valid_o) seen = 1'b1;
            end
            check("abort_no_valid", {63'd0, seen}, 64'd0);
        end
        check("abort_in_ready", {63'd0, bus_if.in_ready_o}, 64'd1);
        check("abort_out_data", {32'd0, bus_if.out_data_o}, 64'd0);
`ifdef NEUR_REQUANT_SAT_CNT_EN
        check("abort_sat_cnt", {48'd0, sat_cnt_o}, 64'd0);
`endif
        run_set("after_abort", {32'd16, 32'd32, -32'sd48, 32'd0}, 32'h02020202, {4{5'd4}},
                1'b0, 2'b00, 32'h0204FA00);
`ifdef NEUR_REQUANT_SAT_CNT_EN
        @(negedge clk_i_fast);
        sat_clr_i = 1'b1;
        @(negedge clk_i_fast);
        sat_clr_i = 1'b0;
        check("sat_clr", {48'd0, sat_cnt_o}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
